// File: rtl/swap_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : swap_pkg
//  Description : Shared types and helpers for the swap request arbiter:
//                swap-mode encoding and byte-lane count helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package swap_pkg;

    // Per-word reordering applied by the lane swap unit
    typedef enum logic [1:0] {
        SWAP_NONE = 2'd0,   // pass-through
        SWAP_NIB  = 2'd1,   // nibble swap inside each byte
        SWAP_BYTE = 2'd2,   // byte reverse
        SWAP_BOTH = 2'd3    // byte reverse, then nibble swap
    } swap_mode_e;

    // Number of byte lanes in a word of width w
    function automatic int lane_count(input int w);
        return w / 8;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lane_swap.sv
`default_nettype none
// ============================================================================
//  Module      : lane_swap
//  Description : Purely combinational byte/nibble reorder of one W-bit word
//                under control of a 2-bit swap mode.
//  Revision    : 1.0 - initial release
// ============================================================================
module lane_swap
    import swap_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [W-1:0] in,
    input  logic [1:0]   mode,
    output logic [W-1:0] out
);

    localparam int c_LANES = lane_count(W);

    logic [W-1:0] w_rev;    // byte-reversed word
    logic [W-1:0] w_nib;    // nibble-swapped word
    logic [W-1:0] w_both;   // byte-reversed then nibble-swapped

    generate
        for (genvar k = 0; k < c_LANES; k++) begin : g_lane
            assign w_rev[k*8 +: 8]  = in[(c_LANES-1-k)*8 +: 8];
            assign w_nib[k*8 +: 8]  = {in[k*8 +: 4], in[k*8+4 +: 4]};
            assign w_both[k*8 +: 8] = {w_rev[k*8 +: 4], w_rev[k*8+4 +: 4]};
        end
    endgenerate

    // Select the reordered view requested by the mode
    always_comb begin
        out = in;
        case (swap_mode_e'(mode))
            SWAP_NONE: out = in;
            SWAP_NIB:  out = w_nib;
            SWAP_BYTE: out = w_rev;
            SWAP_BOTH: out = w_both;
            default:   out = in;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/swap_req_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : swap_req_arbiter
//  Description : Round-robin arbiter sharing one lane swap unit among NREQ
//                requesters, feeding a single-entry valid/ready output
//                register tagged with the winning requester id.
//  Revision    : 1.0 - initial release
// ============================================================================
module swap_req_arbiter
    import swap_pkg::*;
#(
    parameter  int NREQ = 4,
    parameter  int W    = 32,
    localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_data,
    input  logic [NREQ*2-1:0] req_mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [W-1:0]      out_data,
    output logic [IDW-1:0]    out_id
);

    logic [IDW-1:0] r_rr_ptr;       // highest-priority requester this cycle
    logic           r_out_valid;
    logic [W-1:0]   r_out_data;
    logic [IDW-1:0] r_out_id;

    logic           w_found;        // some requester is valid
    logic [IDW-1:0] w_grant_idx;    // winning requester index
    logic           w_can_accept;   // output register can take a word now
    logic           w_accept;       // a grant is accepted this cycle
    logic [W-1:0]   w_sel_data;
    logic [1:0]     w_sel_mode;
    logic [W-1:0]   w_swapped;
    logic [IDW-1:0] w_next_ptr;

    // Round-robin search: first valid requester starting at r_rr_ptr, wrapping
    // modulo NREQ so non-power-of-2 counts wrap correctly.
    always_comb begin
        int idx;
        idx         = 0;
        w_found     = 1'b0;
        w_grant_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(r_rr_ptr) + k) % NREQ;
            if (!w_found && req_valid[idx]) begin
                w_found     = 1'b1;
                w_grant_idx = IDW'(idx);
            end
        end
    end

    assign w_can_accept = !r_out_valid || out_ready;
    assign w_accept     = w_found && w_can_accept;

    // One-hot accept back to the winning requester only
    always_comb begin
        req_ready = '0;
        if (w_accept) begin
            req_ready[w_grant_idx] = 1'b1;
        end
    end

    assign w_sel_data = req_data[w_grant_idx*W +: W];
    assign w_sel_mode = req_mode[w_grant_idx*2 +: 2];
    assign w_next_ptr = IDW'((int'(w_grant_idx) + 1) % NREQ);

    lane_swap #(
        .W    (W)
    ) u_lane_swap (
        .in   (w_sel_data),
        .mode (w_sel_mode),
        .out  (w_swapped)
    );

    // Output register and pointer: load on accept, drain clears valid only,
    // stall holds everything. Pointer moves only on an accepted grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_id    <= '0;
            r_rr_ptr    <= '0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_swapped;
            r_out_id    <= w_grant_idx;
            r_rr_ptr    <= w_next_ptr;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_id    = r_out_id;

endmodule
`default_nettype wire

// File: tb/tb_swap_req_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_swap_req_arbiter
//  Description : Directed, table-driven bench for swap_req_arbiter with a
//                4-requester instance and a 3-requester instance.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_swap_req_arbiter;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    // 4-requester instance
    logic [3:0]   r4_valid;
    logic [3:0]   w4_ready;
    logic [127:0] r4_data;
    logic [7:0]   r4_mode;
    logic         w4_ov;
    logic         r4_oready;
    logic [31:0]  w4_odata;
    logic [1:0]   w4_oid;

    swap_req_arbiter #(.NREQ(4), .W(32)) u_dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (r4_valid),
        .req_ready (w4_ready),
        .req_data  (r4_data),
        .req_mode  (r4_mode),
        .out_valid (w4_ov),
        .out_ready (r4_oready),
        .out_data  (w4_odata),
        .out_id    (w4_oid)
    );

    // 3-requester instance
    logic [2:0]   r3_valid;
    logic [2:0]   w3_ready;
    logic [95:0]  r3_data;
    logic [5:0]   r3_mode;
    logic         w3_ov;
    logic         r3_oready;
    logic [31:0]  w3_odata;
    logic [1:0]   w3_oid;

    swap_req_arbiter #(.NREQ(3), .W(32)) u_dut3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (r3_valid),
        .req_ready (w3_ready),
        .req_data  (r3_data),
        .req_mode  (r3_mode),
        .out_valid (w3_ov),
        .out_ready (r3_oready),
        .out_data  (w3_odata),
        .out_id    (w3_oid)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [3:0]   valid;
        logic [127:0] data;
        logic [7:0]   mode;
        logic         oready;
        logic [3:0]   exp_ready;
        logic         exp_ov;
        logic [31:0]  exp_data;
        logic [1:0]   exp_id;
    } vec_t;

    vec_t vt[7];

    logic [31:0] d4 [4];
    int          exp_seq [6];

    initial begin
        // ---------------- vector table (4-requester instance) ----------------
        vt[0] = '{4'b0001, {32'h0, 32'h0, 32'h0, 32'ha5a5a5a5}, 8'b00_00_00_01, 1'b1,
                  4'b0001, 1'b1, 32'h5a5a5a5a, 2'd0};
        vt[1] = '{4'b0100, {32'h0, 32'h12345678, 32'h0, 32'h0}, 8'b00_10_00_00, 1'b1,
                  4'b0100, 1'b1, 32'h78563412, 2'd2};
        vt[2] = '{4'b0100, {32'h0, 32'h12345678, 32'h0, 32'h0}, 8'b00_11_00_00, 1'b1,
                  4'b0100, 1'b1, 32'h87654321, 2'd2};
        vt[3] = '{4'b0100, {32'h0, 32'h12345678, 32'h0, 32'h0}, 8'b00_00_00_00, 1'b1,
                  4'b0100, 1'b1, 32'h12345678, 2'd2};
        // drain without refill, then an idle cycle: data/id hold
        vt[4] = '{4'b0000, 128'h0, 8'h00, 1'b1, 4'b0000, 1'b0, 32'h12345678, 2'd2};
        vt[5] = '{4'b0000, 128'h0, 8'h00, 1'b1, 4'b0000, 1'b0, 32'h12345678, 2'd2};
        // pointer sits at 3 after the idle cycles: requester 3 wins, nibble swap
        vt[6] = '{4'b1000, {32'h9abcdef0, 32'h0, 32'h0, 32'h0}, 8'b01_00_00_00, 1'b1,
                  4'b1000, 1'b1, 32'ha9cbed0f, 2'd3};

        d4[0] = 32'h11111111;
        d4[1] = 32'h22222222;
        d4[2] = 32'h33333333;
        d4[3] = 32'h44444444;

        r4_valid = '0; r4_data = '0; r4_mode = '0; r4_oready = 1'b0;
        r3_valid = '0; r3_data = '0; r3_mode = '0; r3_oready = 1'b0;

        // ---------------- reset ----------------
        rst_n = 1'b0;
        #2;
        chk("reset out_valid", 32'(w4_ov), 32'h0);
        chk("reset out_data", w4_odata, 32'h0);
        chk("reset out_id", 32'(w4_oid), 32'h0);
        chk("reset req_ready", 32'(w4_ready), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // ---------------- table ----------------
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            r4_valid  = vt[i].valid;
            r4_data   = vt[i].data;
            r4_mode   = vt[i].mode;
            r4_oready = vt[i].oready;
            #1;
            chk($sformatf("vec%0d req_ready", i), 32'(w4_ready), 32'(vt[i].exp_ready));
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d out_valid", i), 32'(w4_ov), 32'(vt[i].exp_ov));
            chk($sformatf("vec%0d out_data", i), w4_odata, vt[i].exp_data);
            chk($sformatf("vec%0d out_id", i), 32'(w4_oid), 32'(vt[i].exp_id));
        end

        // ---------------- round robin, all valid (pointer at 0) ----------------
        exp_seq = '{0, 1, 2, 3, 0, 1};
        @(negedge clk);
        r4_data   = {d4[3], d4[2], d4[1], d4[0]};
        r4_mode   = 8'h00;
        r4_valid  = 4'b1111;
        r4_oready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("rr_all[%0d] out_valid", i), 32'(w4_ov), 32'h1);
            chk($sformatf("rr_all[%0d] out_id", i), 32'(w4_oid), 32'(exp_seq[i]));
            chk($sformatf("rr_all[%0d] out_data", i), w4_odata, d4[exp_seq[i]]);
        end

        // ---------------- requester 1 dropped (pointer at 2) ----------------
        exp_seq = '{2, 3, 0, 2, 3, 0};
        @(negedge clk);
        r4_valid = 4'b1101;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("rr_drop1[%0d] out_valid", i), 32'(w4_ov), 32'h1);
            chk($sformatf("rr_drop1[%0d] out_id", i), 32'(w4_oid), 32'(exp_seq[i]));
        end

        // ---------------- stall 3 cycles, then drain+refill (pointer at 1) ----
        @(negedge clk);
        r4_valid  = 4'b1111;
        r4_oready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("stall[%0d] req_ready", i), 32'(w4_ready), 32'h0);
            @(posedge clk);
            #1;
            chk($sformatf("stall[%0d] out_valid", i), 32'(w4_ov), 32'h1);
            chk($sformatf("stall[%0d] out_id", i), 32'(w4_oid), 32'h0);
            chk($sformatf("stall[%0d] out_data", i), w4_odata, d4[0]);
            @(negedge clk);
        end
        r4_oready = 1'b1;
        #1;
        chk("unstall req_ready", 32'(w4_ready), 32'h2);
        @(posedge clk);
        #1;
        chk("unstall out_valid", 32'(w4_ov), 32'h1);
        chk("unstall out_id", 32'(w4_oid), 32'h1);
        chk("unstall out_data", w4_odata, d4[1]);

        // ---------------- async reset while out_valid=1 ----------------
        @(negedge clk);
        r4_valid = '0;
        rst_n    = 1'b0;
        #1;
        chk("async reset out_valid", 32'(w4_ov), 32'h0);
        chk("async reset out_data", w4_odata, 32'h0);
        chk("async reset out_id", 32'(w4_oid), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // ---------------- NREQ=3: requesters 0 and 2, pointer wrap ----------
        exp_seq = '{0, 2, 0, 2, 0, 2};
        @(negedge clk);
        r3_data   = {32'h0f1e2d3c, 32'h0, 32'hcafef00d};
        r3_mode   = 6'b01_00_10;
        r3_valid  = 3'b101;
        r3_oready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("n3[%0d] out_valid", i), 32'(w3_ov), 32'h1);
            chk($sformatf("n3[%0d] out_id", i), 32'(w3_oid), 32'(exp_seq[i]));
            chk($sformatf("n3[%0d] out_data", i), w3_odata,
                (exp_seq[i] == 0) ? 32'h0df0feca : 32'hf0e1d2c3);
        end
        @(negedge clk);
        r3_valid = '0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Safety net: the stimulus above is fixed-length; this only fires on a hang
    initial begin
        #100000;
        $display("FAIL timeout: got running, expected finished");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/swap_req_arbiter.md
Name: swap_req_arbiter

Overview:
- Shares one byte-lane swap datapath among NREQ requesters. Each requester supplies a W-bit word and a 2-bit swap mode.
- A round-robin arbiter grants one requester per cycle. The selected word passes through the combinational swap unit into a single-entry output register with valid/ready backpressure.
- Sits between multiple producers and one consumer that needs nibble- or byte-reordered data.

Parameters:
- NREQ, 4, number of requesters (1..16).
- W, 32, data width in bits; must be a multiple of 8 and at least 8.
- IDW, (NREQ>1 ? $clog2(NREQ) : 1), width of the requester id tag (derived; not overridden).

Ports:
- clk  input  1  clock; all state on posedge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NREQ  per-requester request valid.
- req_ready  output  NREQ  per-requester accept; at most one bit high.
- req_data  input  NREQ*W  packed words; requester i occupies [i*W +: W].
- req_mode  input  NREQ*2  packed modes; requester i occupies [i*2 +: 2].
- out_valid  output  1  result register holds valid data.
- out_ready  input  1  consumer accepts the result.
- out_data  output  W  swapped word.
- out_id  output  IDW  index of the requester that produced out_data.

Behaviour:
- Reset (async assert, sync release): out_valid=0, out_data=0, out_id=0, rr_ptr=0. A transfer in flight at reset is discarded; there is no recovery.
- Swap modes, applied per byte lane k:
  - 0 = pass-through.
  - 1 = nibble swap inside each byte, lane k becomes {b[3:0],b[7:4]}.
  - 2 = byte reverse: lane k takes lane (W/8-1-k).
  - 3 = byte reverse, then nibble swap.
- can_accept = !out_valid || out_ready.
- Grant selection: the first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, ... modulo NREQ.
- req_ready[i] = can_accept && grant[i]. It depends on req_valid but never on req_ready, so there is no combinational loop. out_ready may combinationally affect req_ready.
- On the posedge where any req_ready[i]=1:
  - out_data <= swap(req_data[i], req_mode[i]); out_id <= i; out_valid <= 1.
  - rr_ptr <= (i+1) mod NREQ.
- Drain without refill (out_valid && out_ready, no grant): out_valid <= 0. out_data and out_id hold their last values.
- Stall (out_valid && !out_ready): out_data, out_id and out_valid hold. All req_ready are 0.
- Latency is 1 cycle from accept to out_valid. Simultaneous drain and refill in the same cycle gives full throughput of 1 word/cycle.
- Requesters must hold valid, data and mode stable until accepted. The arbiter does not latch unaccepted requests.
- rr_ptr changes only on an accepted grant. Idle cycles do not advance it.
- NREQ=1: the arbiter degenerates to a pass-through register; out_id is always 0.
- rr_ptr wrap: (NREQ-1)+1 -> 0. Non-power-of-2 NREQ must wrap correctly, e.g. NREQ=3 gives 2 -> 0.

Decomposition:
- Package swap_pkg:
  - typedef enum swap_mode_e {SWAP_NONE=0, SWAP_NIB=1, SWAP_BYTE=2, SWAP_BOTH=3}.
  - function or constant helpers for lane count W/8.
- Sub-module lane_swap: purely combinational, parameter W, ports in[W], mode[2], out[W]. Instantiate it once, after the grant mux.
- The top level holds the round-robin pointer, grant logic, mux and output register.

Test Plan:
- Reset with all inputs at 0 -> out_valid=0, out_data=0, out_id=0, req_ready=0. Assert rst_n=0 while out_valid=1 -> out_valid drops immediately.
- Requester 0 only, data 0xa5a5a5a5, mode 1, out_ready=1 -> req_ready[0]=1 in the same cycle; next cycle out_data=0x5a5a5a5a, out_id=0.
- Requester 2, data 0x12345678, mode 2 -> out_data=0x78563412. Mode 3 -> 0x87654321. Mode 0 -> 0x12345678.
- All four requesters valid continuously, out_ready=1 -> out_id sequence 0,1,2,3,0,1 with out_valid high every cycle. Drop requester 1 -> sequence 2,3,0,2,3,0.
- Result pending, out_ready held low 3 cycles with all requests valid -> out_data and out_id stable, req_ready all 0. Raise out_ready -> drain and new grant occur in the same cycle.
- NREQ=3 build, requesters 2 and 0 valid -> grants alternate 0,2,0,2 and rr_ptr wraps 2 -> 0.
